dc_offset_loop: RTL and testbench

Loop-filter and correction stage directly downstream of `dc_error`. On each accumulated-error pulse it scales the 38-bit block error sum by a programmable power-of-two step size and integrates it into a saturating DC estimate. It subtracts that estimate from the incoming 1s17 sample stream, which closes the DC-removal loop ahead of the slicer.

---
 rtl/dc_offset_loop.sv | 148 ++++++++++++++
 tb/tb_dc_offset_loop.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dc_offset_loop.sv
// rtl/dc_offset_loop.sv - DC loop filter/integrator and sample-path DC correction.
// Optional lock detector enabled by defining DC_LOCK_DET_EN.
module dc_offset_loop #(
    parameter logic signed [37:0] LOCK_THR   = 38'sd4096,
    parameter int                 LOCK_COUNT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               acc_valid,
    input  logic signed [37:0] acc_in,
    input  logic [3:0]         mu_shift,
    input  logic               freeze,
    input  logic signed [17:0] sample_in,
    output logic signed [17:0] sample_out,
    output logic signed [17:0] dc_est,
    output logic               busy,
    output logic               overrun,
    output logic [15:0]        update_count,
    output logic               locked
);

    typedef enum logic [1:0] {IDLE, SCALE, ADD} state_t;

    localparam logic signed [46:0] ACC_MAX = 47'sd33554431;
    localparam logic signed [46:0] ACC_MIN = -47'sd33554432;

    state_t             state, state_next;
    logic signed [37:0] cap_r;
    logic signed [37:0] pend_r;
    logic               pend_full;
    logic signed [45:0] step_r;
    logic signed [25:0] dc_acc;
    logic signed [45:0] cap_wide;
    logic signed [45:0] step_next;
    logic signed [46:0] sum_w;
    logic signed [25:0] sum_sat;
    logic signed [18:0] diff_w;
    logic signed [17:0] diff_sat;

    assign dc_est    = dc_acc[25:8];
    assign cap_wide  = {cap_r, 8'b0};
    assign step_next = cap_wide >>> mu_shift;
    assign sum_w     = {{21{dc_acc[25]}}, dc_acc} + {step_r[45], step_r};
    assign sum_sat   = (sum_w > ACC_MAX) ? ACC_MAX[25:0] :
                       (sum_w < ACC_MIN) ? ACC_MIN[25:0] : sum_w[25:0];
    assign diff_w    = {sample_in[17], sample_in} - {dc_est[17], dc_est};
    // Overflow of the 19-bit difference shows up as bits 18 and 17 disagreeing.
    assign diff_sat  = (diff_w[18] != diff_w[17]) ? {diff_w[18], {17{~diff_w[18]}}}
                                                   : diff_w[17:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (acc_valid) state_next = SCALE;
            SCALE:   state_next = ADD;
            ADD:     state_next = (pend_full || acc_valid) ? SCALE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_r        <= '0;
            pend_r       <= '0;
            pend_full    <= 1'b0;
            step_r       <= '0;
            dc_acc       <= '0;
            update_count <= '0;
            overrun      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc_valid) cap_r <= acc_in;
                end
                SCALE: begin
                    step_r <= step_next;
                    if (acc_valid) begin
                        if (pend_full) overrun <= 1'b1;
                        else begin
                            pend_r    <= acc_in;
                            pend_full <= 1'b1;
                        end
                    end
                end
                ADD: begin
                    if (!freeze) begin
                        dc_acc <= sum_sat;
                        if (update_count != 16'hFFFF) update_count <= update_count + 16'd1;
                    end
                    // An arrival in ADD with the slot empty goes straight into cap_r.
                    if (pend_full) begin
                        cap_r     <= pend_r;
                        pend_full <= 1'b0;
                        if (acc_valid) overrun <= 1'b1;
                    end else if (acc_valid) begin
                        cap_r <= acc_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)       sample_out <= '0;
        else if (clk_en) sample_out <= diff_sat;
    end

`ifdef DC_LOCK_DET_EN
    localparam logic [3:0]  LOCK_CNT4 = 4'(LOCK_COUNT);
    localparam logic [38:0] THR_MAG   = {LOCK_THR[37], LOCK_THR};

    logic [3:0]  lock_cnt;
    logic [38:0] cap_mag;
    logic        locked_r;

    assign cap_mag = cap_r[37] ? -{cap_r[37], cap_r} : {cap_r[37], cap_r};
    assign locked  = locked_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt <= '0;
            locked_r <= 1'b0;
        end else if (state == ADD) begin
            if (cap_mag <= THR_MAG) begin
                if (lock_cnt != LOCK_CNT4) lock_cnt <= lock_cnt + 4'd1;
                if ((lock_cnt + 4'd1 == LOCK_CNT4) || (lock_cnt == LOCK_CNT4)) locked_r <= 1'b1;
            end else begin
                lock_cnt <= '0;
                locked_r <= 1'b0;
            end
        end
    end
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_dc_offset_loop.sv
// tb/tb_dc_offset_loop.sv - scoreboard bench for dc_offset_loop.
module tb_dc_offset_loop;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               clk_en = 1'b0;
    logic               acc_valid = 1'b0;
    logic signed [37:0] acc_in = '0;
    logic [3:0]         mu_shift = '0;
    logic               freeze = 1'b0;
    logic signed [17:0] sample_in = '0;
    logic signed [17:0] sample_out;
    logic signed [17:0] dc_est;
    logic               busy;
    logic               overrun;
    logic [15:0]        update_count;
    logic               locked;

    typedef struct {
        int dc;
        int cnt;
        int ovr;
        int lck;
        int blen;
    } upd_t;

    upd_t upd_q[$];
    int   samp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   busy_run = 0;
    bit   rst_at_edge = 1'b0;
    bit   en_at_edge = 1'b0;
    int   lock_en;

    dc_offset_loop dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .acc_valid(acc_valid),
        .acc_in(acc_in), .mu_shift(mu_shift), .freeze(freeze),
        .sample_in(sample_in), .sample_out(sample_out), .dc_est(dc_est),
        .busy(busy), .overrun(overrun), .update_count(update_count), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        rst_at_edge <= reset;
        en_at_edge  <= clk_en & ~reset;
    end

    // Monitor: reset state, completed update bursts and enabled sample edges.
    always @(negedge clk) begin
        upd_t e;
        int   s;
        if (rst_at_edge) begin
            busy_run = 0;
            check("rst_dc_est", dc_est, 0);
            check("rst_sample_out", sample_out, 0);
            check("rst_update_count", update_count, 0);
            check("rst_busy", busy, 0);
            check("rst_overrun", overrun, 0);
            check("rst_locked", locked, 0);
        end else begin
            if (busy) busy_run++;
            else if (busy_run > 0) begin
                if (upd_q.size() == 0) check("unexpected_update", 1, 0);
                else begin
                    e = upd_q.pop_front();
                    check("dc_est", dc_est, e.dc);
                    check("update_count", update_count, e.cnt);
                    check("overrun", overrun, e.ovr);
                    check("locked", locked, e.lck);
                    check("busy_cycles", busy_run, e.blen);
                end
                busy_run = 0;
            end
            if (en_at_edge) begin
                if (samp_q.size() == 0) check("unexpected_sample", 1, 0);
                else begin
                    s = samp_q.pop_front();
                    check("sample_out", sample_out, s);
                end
            end
        end
    end

    task automatic exp_upd(input int dc, input int cnt, input int ovr, input int lck, input int blen);
        upd_t e;
        e.dc = dc; e.cnt = cnt; e.ovr = ovr; e.lck = lck; e.blen = blen;
        upd_q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse(input int val);
        acc_valid = 1'b1;
        acc_in = 38'(val);
        @(posedge clk); #1;
        acc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL wait_idle: busy still %0d after 50 cycles, required 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic sample(input int val, input int exp);
        clk_en = 1'b1;
        sample_in = 18'(val);
        samp_q.push_back(exp);
        @(posedge clk); #1;
        clk_en = 1'b0;
    endtask

    initial begin
`ifdef DC_LOCK_DET_EN
        lock_en = 1;
`else
        lock_en = 0;
`endif
        // Basic update and correction
        do_reset();
        mu_shift = 4'd0;
        exp_upd(1000, 1, 0, 0, 2);
        pulse(1000);
        wait_idle();
        sample(5000, 4000);

        // Step scaling with mu_shift = 4
        do_reset();
        mu_shift = 4'd4;
        exp_upd(-10, 1, 0, 0, 2);
        pulse(-160);
        wait_idle();
        exp_upd(-20, 2, 0, 0, 2);
        pulse(-160);
        wait_idle();
        sample(0, 20);

        // Estimate and sample saturation
        do_reset();
        mu_shift = 4'd0;
        exp_upd(131071, 1, 0, 0, 2);
        pulse(1 << 20);
        wait_idle();
        sample(-131072, -131072);
        sample(131071, 0);

        // Three consecutive pulses: third dropped
        do_reset();
        exp_upd(300, 2, 1, 0, 4);
        acc_valid = 1'b1;
        acc_in = 38'sd100; @(posedge clk); #1;
        acc_in = 38'sd200; @(posedge clk); #1;
        acc_in = 38'sd300; @(posedge clk); #1;
        acc_valid = 1'b0;
        wait_idle();

        // One pulse per 2 cycles sustained without overrun
        do_reset();
        exp_upd(60, 3, 0, 0, 6);
        pulse(10);
        @(posedge clk); #1;
        pulse(20);
        @(posedge clk); #1;
        pulse(30);
        wait_idle();

        // Freeze holds estimate and count
        do_reset();
        exp_upd(1000, 1, 0, 0, 2);
        pulse(1000);
        wait_idle();
        freeze = 1'b1;
        exp_upd(1000, 1, 0, 0, 2);
        pulse(500);
        wait_idle();
        freeze = 1'b0;

        // Reset during SCALE, then a clean update
        pulse(700);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_upd(50, 1, 0, 0, 2);
        pulse(50);
        wait_idle();

        // Lock detection
        do_reset();
        for (int i = 0; i < 8; i++) begin
            exp_upd(100 * (i + 1), i + 1, 0, (lock_en != 0 && i == 7) ? 1 : 0, 2);
            pulse(100);
            wait_idle();
        end
        exp_upd(5800, 9, 0, 0, 2);
        pulse(5000);
        wait_idle();

        repeat (4) @(posedge clk);
        check("upd_queue_drained", upd_q.size(), 0);
        check("samp_queue_drained", samp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
